// File: rtl/time_pkg.sv
// time_pkg: shared constants for the seconds-of-day decoder.
//   MAX_TIME / SEC_PER_HOUR / SEC_PER_MIN : calendar constants
//   W_H10..W_S10                          : per-digit subtract weights
//   ST_*                                  : decoder state encoding
//   weight_of()                           : weight selected by state
package time_pkg;

    localparam int TIME_W       = 18;
    localparam int MAX_TIME     = 86400;
    localparam int SEC_PER_HOUR = 3600;
    localparam int SEC_PER_MIN  = 60;

    localparam int unsigned W_H10 = 10 * SEC_PER_HOUR;
    localparam int unsigned W_H1  = SEC_PER_HOUR;
    localparam int unsigned W_M10 = 10 * SEC_PER_MIN;
    localparam int unsigned W_M1  = SEC_PER_MIN;
    localparam int unsigned W_S10 = 10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_H10  = 3'd1;
    localparam logic [2:0] ST_H1   = 3'd2;
    localparam logic [2:0] ST_M10  = 3'd3;
    localparam logic [2:0] ST_M1   = 3'd4;
    localparam logic [2:0] ST_S10  = 3'd5;
    localparam logic [2:0] ST_ERRF = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        H10  = ST_H10,
        H1   = ST_H1,
        M10  = ST_M10,
        M1   = ST_M1,
        S10  = ST_S10,
        ERRF = ST_ERRF
    } state_t;

    // Weight subtracted while sitting in a digit state; zero outside them.
    function automatic int unsigned weight_of(input state_t s);
        case (s)
            H10:     return W_H10;
            H1:      return W_H1;
            M10:     return W_M10;
            M1:      return W_M1;
            S10:     return W_S10;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/time_digit_step.sv
// time_digit_step: one compare-subtract step of the iterative decode.
//   rem    : remaining seconds
//   weight : digit weight for the current state
//   ge     : rem >= weight (unsigned)
//   diff   : rem - weight, only meaningful when ge=1
module time_digit_step #(
    parameter int W = 18
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] weight,
    output logic         ge,
    output logic [W-1:0] diff
);

    assign ge   = (rem >= weight);
    assign diff = rem - weight;

endmodule

// File: rtl/time_decoder.sv
// time_decoder: decodes an 18-bit seconds-of-day word into packed BCD
// HH:MM:SS with repeated compare-subtract (no divider).
//   CLK, RESET          : clock, synchronous active-high reset
//   CURR_TIME, START    : request; CURR_TIME sampled only when accepted in IDLE
//   BUSY                : decode in progress, new START ignored
//   DONE                : one-cycle pulse, outputs/ERR updated this cycle
//   ERR                 : last accepted CURR_TIME exceeded max_time
//   HOUR_BCD/MIN_BCD/SEC_BCD : {tens, units} BCD result, held until next DONE
module time_decoder
    import time_pkg::*;
#(
    parameter int time_buff_size = TIME_W,
    parameter int max_time       = MAX_TIME
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [time_buff_size-1:0] CURR_TIME,
    input  logic                      START,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERR,
    output logic [7:0]                HOUR_BCD,
    output logic [7:0]                MIN_BCD,
    output logic [7:0]                SEC_BCD
);

    localparam logic [time_buff_size-1:0] MAX_W = time_buff_size'(max_time);

    state_t                    state, state_nxt;
    logic [time_buff_size-1:0] rem, rem_nxt;
    logic [time_buff_size-1:0] weight, diff;
    logic                      ge;

    logic [3:0] h10, h1, m10, m1, s10;
    logic [3:0] h10_nxt, h1_nxt, m10_nxt, m1_nxt, s10_nxt;

    logic       busy_nxt, done_nxt, err_nxt;
    logic [7:0] hour_nxt, min_nxt, sec_nxt;

    // Single shared subtractor; the state picks which weight it sees.
    assign weight = time_buff_size'(weight_of(state));

    time_digit_step #(.W(time_buff_size)) u_step (
        .rem    (rem),
        .weight (weight),
        .ge     (ge),
        .diff   (diff)
    );

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        h10_nxt   = h10;
        h1_nxt    = h1;
        m10_nxt   = m10;
        m1_nxt    = m1;
        s10_nxt   = s10;
        busy_nxt  = BUSY;
        done_nxt  = 1'b0;
        err_nxt   = ERR;
        hour_nxt  = HOUR_BCD;
        min_nxt   = MIN_BCD;
        sec_nxt   = SEC_BCD;

        case (state)
            IDLE: begin
                if (START) begin
                    busy_nxt = 1'b1;
                    h10_nxt  = 4'd0;
                    h1_nxt   = 4'd0;
                    m10_nxt  = 4'd0;
                    m1_nxt   = 4'd0;
                    s10_nxt  = 4'd0;
                    rem_nxt  = CURR_TIME;
                    if (CURR_TIME > MAX_W) begin
                        state_nxt = ERRF;
                    end else begin
                        // Exactly max_time is the midnight wrap: decode as 00:00:00.
                        if (CURR_TIME == MAX_W)
                            rem_nxt = '0;
                        state_nxt = H10;
                    end
                end
            end

            H10, H1, M10, M1, S10: begin
                if (ge) begin
                    rem_nxt = diff;
                    case (state)
                        H10:     h10_nxt = h10 + 4'd1;
                        H1:      h1_nxt  = h1  + 4'd1;
                        M10:     m10_nxt = m10 + 4'd1;
                        M1:      m1_nxt  = m1  + 4'd1;
                        default: s10_nxt = s10 + 4'd1;
                    endcase
                end else begin
                    case (state)
                        H10:     state_nxt = H1;
                        H1:      state_nxt = M10;
                        M10:     state_nxt = M1;
                        M1:      state_nxt = S10;
                        default: begin
                            // rem < 10 here, so its low nibble is the seconds unit.
                            hour_nxt  = {h10, h1};
                            min_nxt   = {m10, m1};
                            sec_nxt   = {s10, rem[3:0]};
                            done_nxt  = 1'b1;
                            err_nxt   = 1'b0;
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    endcase
                end
            end

            ERRF: begin
                hour_nxt  = 8'h00;
                min_nxt   = 8'h00;
                sec_nxt   = 8'h00;
                err_nxt   = 1'b1;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end

            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            rem      <= '0;
            h10      <= 4'd0;
            h1       <= 4'd0;
            m10      <= 4'd0;
            m1       <= 4'd0;
            s10      <= 4'd0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            HOUR_BCD <= 8'h00;
            MIN_BCD  <= 8'h00;
            SEC_BCD  <= 8'h00;
        end else begin
            state    <= state_nxt;
            rem      <= rem_nxt;
            h10      <= h10_nxt;
            h1       <= h1_nxt;
            m10      <= m10_nxt;
            m1       <= m1_nxt;
            s10      <= s10_nxt;
            BUSY     <= busy_nxt;
            DONE     <= done_nxt;
            ERR      <= err_nxt;
            HOUR_BCD <= hour_nxt;
            MIN_BCD  <= min_nxt;
            SEC_BCD  <= sec_nxt;
        end
    end

endmodule

// File: tb/tb_time_decoder.sv
// tb_time_decoder: scoreboard bench for time_decoder. The driver predicts
// each accepted request with plain division/modulo and queues it; a negedge
// monitor pops on DONE and also tracks BUSY and held outputs every cycle.
module tb_time_decoder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [17:0] CURR_TIME;
    logic        START;
    logic        BUSY, DONE, ERR;
    logic [7:0]  HOUR_BCD, MIN_BCD, SEC_BCD;

    time_decoder dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CURR_TIME (CURR_TIME),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .HOUR_BCD  (HOUR_BCD),
        .MIN_BCD   (MIN_BCD),
        .SEC_BCD   (SEC_BCD)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         done_cyc;
        logic [24:0] res;      // {err, hour, min, sec}
    } exp_t;

    exp_t        q[$];
    logic [24:0] last_res = '0;
    int          cap_cyc  = 0;
    int          busy_end = 0;
    int          total    = 0;
    int          bad      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Reference: arithmetic on seconds-of-day; latency = 5 + sum of all
    // digits except seconds units (each digit state costs digit+1 cycles).
    function automatic exp_t model(input int t, input int c);
        exp_t e;
        int s2, h, m, s;
        if (t > 86400) begin
            e.done_cyc = c + 1;
            e.res      = {1'b1, 24'h0};
        end else begin
            s2 = (t == 86400) ? 0 : t;
            h  = s2 / 3600;
            m  = (s2 % 3600) / 60;
            s  = s2 % 60;
            e.done_cyc = c + 5 + h / 10 + h % 10 + m / 10 + m % 10 + s / 10;
            e.res      = {1'b0, bcd(h), bcd(m), bcd(s)};
        end
        return e;
    endfunction

    // All driver tasks are entered at posedge+1 and return at posedge+1.
    task automatic start_req(input int t);
        exp_t e;
        int   c;
        #1;
        START     = 1'b1;
        CURR_TIME = 18'(t);
        @(posedge CLK);
        #1;
        START = 1'b0;
        c = cyc;
        if (c > busy_end) begin
            e = model(t, c);
            q.push_back(e);
            cap_cyc  = c;
            busy_end = e.done_cyc;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            #1;
            CURR_TIME = 18'($urandom);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (cyc < busy_end && k < 200) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (cyc < busy_end) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: cycle %0d expected done by %0d", cyc, busy_end);
        end
    endtask

    task automatic do_reset();
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        q.delete();
        last_res = '0;
        cap_cyc  = cyc;
        busy_end = cyc;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (DONE === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(DONE), 32'(0));
            end else begin
                e = q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                last_res = e.res;
            end
        end
        chk("result", 32'({ERR, HOUR_BCD, MIN_BCD, SEC_BCD}), 32'(last_res));
        chk("busy", 32'(BUSY), 32'((cyc >= cap_cyc) && (cyc < busy_end)));
    end

    initial begin
        int t, r;
        RESET     = 1'b1;
        START     = 1'b0;
        CURR_TIME = '0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle_cycles(2);

        // Directed corners; each waits only until DONE, so the next START
        // lands in the DONE cycle (back-to-back acceptance).
        start_req(0);      wait_idle();
        start_req(45296);  wait_idle();
        start_req(86399);  wait_idle();
        start_req(86400);  wait_idle();
        start_req(86401);  wait_idle();
        start_req(3661);   wait_idle();

        // START while busy is dropped.
        start_req(45296);
        idle_cycles(2);
        start_req(0);
        wait_idle();
        start_req(45296);  wait_idle();

        // Reset 10 cycles into a decode: abandoned, no DONE.
        start_req(45296);
        idle_cycles(8);
        do_reset();
        idle_cycles(3);
        start_req(45296);  wait_idle();
        start_req(262143); wait_idle();

        repeat (60) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       t = 86398 + $urandom_range(0, 4);
                1:       t = $urandom_range(0, 262143);
                2:       t = $urandom_range(0, 15);
                default: t = $urandom_range(0, 86399);
            endcase
            start_req(t);
            idle_cycles($urandom_range(0, 30));
        end

        wait_idle();
        idle_cycles(3);
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
